uart_config_rx: RTL and testbench
=================================

// Module: uart_config_rx
// PURPOSE
//  Receive end of the eFPGA configuration UART. Deserialises 8N1 frames on Rx,
//  packs bytes MSB-first into 32-bit words and issues one-cycle write strobes to
//  the config frame logic. Drives ComActive/ReceiveLED status pins.
// PARAMETERS
//  CLKS_PER_BIT  8     CLK cycles per UART bit; even, >=4
//  IDLE_TIMEOUT  4096  cycles without a byte before ComActive drops and word alignment resets
// PORTS
//  CLK          in   1   system clock; all logic on posedge
//  RST          in   1   synchronous, active-high reset
//  Rx           in   1   async serial input, idle high
//  ByteData     out  8   last received byte
//  ByteValid    out  1   one-cycle pulse; ByteData valid
//  FrameErr     out  1   one-cycle pulse; stop bit sampled low
//  WriteData    out  32  assembled word; first byte received in [31:24]
//  WriteStrobe  out  1   one-cycle pulse; WriteData valid
//  ComActive    out  1   high while a transfer is in progress
//  ReceiveLED   out  1   toggles on every WriteStrobe
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, byte index 0, Rx sync flops preset to 1.
//  Rx passes through 2-flop synchroniser (rx_s); all decisions use rx_s.
//  FSM (bit counter bc, cycle counter cc):
//   IDLE : rx_s==0 -> START, cc=0.
//   START: when cc==CLKS_PER_BIT/2-1 sample rx_s: 1 -> IDLE (glitch, no output);
//          0 -> DATA, cc=0, bc=0.
//   DATA : when cc==CLKS_PER_BIT-1 sample rx_s into shift[bc], LSB first, cc=0;
//          after bc==7 -> STOP.
//   STOP : when cc==CLKS_PER_BIT-1 sample rx_s: 1 -> ByteValid next cycle, IDLE;
//          0 -> FrameErr next cycle, byte dropped, -> BREAK.
//   BREAK: wait for rx_s==1, then IDLE.
//  All samples fall mid-bit. A start edge seen in the STOP sample cycle is not
//   lost: IDLE detects it on the next cycle.
//  Word packing: on ByteValid, word={word[23:0],ByteData}, idx+=1 (mod 4);
//   when idx was 3, WriteData=word and WriteStrobe pulse on the cycle after
//   ByteValid. Latency: 4th stop-bit sample -> WriteStrobe = 2 cycles.
//  FrameErr does not advance idx and does not clear the partial word.
//  ComActive: set with ByteValid; idle counter reloads on every ByteValid;
//   after IDLE_TIMEOUT cycles without ByteValid, ComActive=0 and idx=0,
//   discarding a partial word. Timeout and ByteValid in the same cycle:
//   ByteValid wins.
//  RST mid-frame: returns to IDLE immediately; partial byte/word discarded;
//   no ByteValid/WriteStrobe.
//  WriteData holds its value between strobes. Outputs are registered, no
//   combinational paths from Rx.
// TESTING
//  1 Send 0xA5 at CLKS_PER_BIT=8 -> one ByteValid, ByteData=0xA5,
//    FrameErr=0, no WriteStrobe, ComActive=1.
//  2 Send 0x12,0x34,0x56,0x78 back-to-back -> one WriteStrobe,
//    WriteData=0x12345678, ReceiveLED 0->1.
//  3 Rx low for 3 cycles then high -> no ByteValid, FSM back in IDLE;
//    next valid 0x3C received correctly.
//  4 Frame 0x55 with stop bit 0, Rx held low 40 cycles -> one FrameErr,
//    no ByteValid; following 0x81 received.
//  5 Send 0xDE,0xAD, wait IDLE_TIMEOUT+10 cycles -> ComActive=0;
//    then 0x01,0x02,0x03,0x04 -> WriteData=0x01020304.
//  6 Assert RST during bit 4 of a frame -> all outputs 0, no strobe;
//    next full frame 0xF0 decoded correctly.

Source files
------------

// File: rtl/uart_config_rx_if.sv
// Output bundle of the configuration UART receiver plus its serial input.
// slave: the receiver side; master: whatever drives Rx and consumes the outputs.
interface uart_config_rx_if;
  logic        Rx;
  logic [7:0]  ByteData;
  logic        ByteValid;
  logic        FrameErr;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        ComActive;
  logic        ReceiveLED;

  modport slave (
    input  Rx,
    output ByteData,
    output ByteValid,
    output FrameErr,
    output WriteData,
    output WriteStrobe,
    output ComActive,
    output ReceiveLED
  );

  modport master (
    output Rx,
    input  ByteData,
    input  ByteValid,
    input  FrameErr,
    input  WriteData,
    input  WriteStrobe,
    input  ComActive,
    input  ReceiveLED
  );
endinterface

// File: rtl/uart_config_rx.sv
// Configuration UART receiver: 8N1 deserialiser, MSB-first 32-bit word packer,
// write strobe generation and activity/LED status.
module uart_config_rx #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned IDLE_TIMEOUT = 4096
) (
  input  logic            CLK,
  input  logic            RST,
  uart_config_rx_if.slave bus
);

  localparam int unsigned CcW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IcW = $clog2(IDLE_TIMEOUT);
  localparam logic [CcW-1:0] CcHalf = CcW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CcW-1:0] CcFull = CcW'(CLKS_PER_BIT - 1);
  localparam logic [IcW-1:0] IcLast = IcW'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e         state_q, state_d;
  logic [CcW-1:0] cc_q, cc_d;
  logic [2:0]     bc_q, bc_d;
  logic [7:0]     shift_q, shift_d;
  logic           byte_done, frame_err;

  logic           rx_meta_q, rx_s_q;

  logic [7:0]     byte_data_q;
  logic           byte_valid_q;
  logic           frame_err_q;
  logic [31:0]    word_q;
  logic [1:0]     idx_q;
  logic [31:0]    write_data_q;
  logic           write_strobe_q;
  logic           com_active_q;
  logic           receive_led_q;
  logic [IcW-1:0] idle_cnt_q;

  // Two-flop synchroniser on Rx, preset to the idle-high line level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM state and counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cc_q    <= '0;
      bc_q    <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      bc_q    <= bc_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: half-bit check of the start bit, then full-bit steps land mid-bit.
  always_comb begin
    state_d   = state_q;
    cc_d      = cc_q + 1'b1;
    bc_d      = bc_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      StIdle: begin
        cc_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (cc_q == CcHalf) begin
          cc_d    = '0;
          bc_d    = '0;
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cc_q == CcFull) begin
          cc_d          = '0;
          shift_d[bc_q] = rx_s_q;
          bc_d          = bc_q + 1'b1;
          if (bc_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cc_q == CcFull) begin
          cc_d = '0;
          if (rx_s_q) begin
            byte_done = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err = 1'b1;
            state_d   = StBreak;
          end
        end
      end
      StBreak: begin
        cc_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        cc_d    = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Registered byte/word outputs, idle timeout and LED; ByteValid beats timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      byte_data_q    <= '0;
      byte_valid_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      word_q         <= '0;
      idx_q          <= '0;
      write_data_q   <= '0;
      write_strobe_q <= 1'b0;
      com_active_q   <= 1'b0;
      receive_led_q  <= 1'b0;
      idle_cnt_q     <= '0;
    end else begin
      byte_valid_q   <= byte_done;
      frame_err_q    <= frame_err;
      write_strobe_q <= 1'b0;
      if (byte_done) byte_data_q <= shift_q;
      if (byte_valid_q) begin
        word_q       <= {word_q[23:0], byte_data_q};
        idx_q        <= idx_q + 1'b1;
        com_active_q <= 1'b1;
        idle_cnt_q   <= '0;
        if (idx_q == 2'd3) begin
          write_data_q   <= {word_q[23:0], byte_data_q};
          write_strobe_q <= 1'b1;
          receive_led_q  <= ~receive_led_q;
        end
      end else if (idle_cnt_q == IcLast) begin
        // Saturated: line has been quiet long enough to drop word alignment.
        com_active_q <= 1'b0;
        idx_q        <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
    end
  end

  assign bus.ByteData    = byte_data_q;
  assign bus.ByteValid   = byte_valid_q;
  assign bus.FrameErr    = frame_err_q;
  assign bus.WriteData   = write_data_q;
  assign bus.WriteStrobe = write_strobe_q;
  assign bus.ComActive   = com_active_q;
  assign bus.ReceiveLED  = receive_led_q;

endmodule

// File: tb/tb_uart_config_rx.sv
// Scoreboarded bench for uart_config_rx: bytes and words expected by a small
// packing model are queued at send time and popped when the DUT strobes.
module tb_uart_config_rx;
  localparam int unsigned CPB = 8;
  localparam int unsigned TMO = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_config_rx_if bus ();

  uart_config_rx #(
    .CLKS_PER_BIT(CPB),
    .IDLE_TIMEOUT(TMO)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int byte_cnt = 0;
  int ferr_cnt = 0;
  int ws_cnt = 0;

  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_words[$];
  logic [31:0] m_word = '0;
  int          m_idx = 0;

  // Monitor: pops the scoreboard whenever the DUT produces a byte or word.
  always @(negedge clk) begin
    logic [7:0]  eb;
    logic [31:0] ew;
    if (rst === 1'b0) begin
      if (bus.ByteValid === 1'b1) begin
        byte_cnt++;
        n_cmp++;
        if (exp_bytes.size() == 0) begin
          n_err++;
          $display("FAIL byte_unexpected: got ByteData=%h, none expected", bus.ByteData);
        end else begin
          eb = exp_bytes.pop_front();
          if (bus.ByteData !== eb) begin
            n_err++;
            $display("FAIL byte_data: got %h, expected %h", bus.ByteData, eb);
          end
        end
      end
      if (bus.FrameErr === 1'b1) ferr_cnt++;
      if (bus.WriteStrobe === 1'b1) begin
        ws_cnt++;
        n_cmp++;
        if (exp_words.size() == 0) begin
          n_err++;
          $display("FAIL word_unexpected: got WriteData=%h, none expected", bus.WriteData);
        end else begin
          ew = exp_words.pop_front();
          if (bus.WriteData !== ew) begin
            n_err++;
            $display("FAIL write_data: got %h, expected %h", bus.WriteData, ew);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_word = '0;
    m_idx  = 0;
    exp_bytes.delete();
    exp_words.delete();
  endtask

  task automatic do_reset();
    bus.Rx = 1'b1;
    rst    = 1'b1;
    tick(3);
    rst = 1'b0;
    model_clear();
    tick(2);
  endtask

  task automatic drive_bit(input logic b);
    bus.Rx = b;
    tick(CPB);
  endtask

  // Full frame; a good stop bit feeds the model before the line is driven.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
    if (stop) begin
      exp_bytes.push_back(d);
      m_word = {m_word[23:0], d};
      if (m_idx == 3) exp_words.push_back(m_word);
      m_idx = (m_idx + 1) % 4;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    bus.Rx = stop;
    tick(stop_len);
    bus.Rx = 1'b1;
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b1, CPB);
  endtask

  task automatic check_drained(input string tag);
    n_cmp++;
    if (exp_bytes.size() != 0 || exp_words.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: %0d bytes / %0d words pending, expected 0 / 0",
               tag, exp_bytes.size(), exp_words.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.ByteValid, bus.FrameErr, bus.WriteStrobe, bus.ComActive, bus.ReceiveLED} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {bus.ByteValid, bus.FrameErr, bus.WriteStrobe, bus.ComActive, bus.ReceiveLED});
    end
    n_cmp++;
    if (bus.WriteData !== 32'h0 || bus.ByteData !== 8'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h/%h, expected 00000000/00", bus.WriteData, bus.ByteData);
    end
  endtask

  task automatic test_single_byte();
    int b0, f0, w0;
    do_reset();
    b0 = byte_cnt; f0 = ferr_cnt; w0 = ws_cnt;
    send(8'hA5);
    tick(4);
    n_cmp++;
    if (byte_cnt - b0 != 1 || ferr_cnt - f0 != 0 || ws_cnt - w0 != 0) begin
      n_err++;
      $display("FAIL single_counts: bv=%0d fe=%0d ws=%0d, expected 1 0 0",
               byte_cnt - b0, ferr_cnt - f0, ws_cnt - w0);
    end
    n_cmp++;
    if (bus.ComActive !== 1'b1) begin
      n_err++;
      $display("FAIL single_com_active: got %b, expected 1", bus.ComActive);
    end
    check_drained("single");
  endtask

  task automatic test_back_to_back();
    int w0;
    do_reset();
    w0 = ws_cnt;
    n_cmp++;
    if (bus.ReceiveLED !== 1'b0) begin
      n_err++;
      $display("FAIL led_before: got %b, expected 0", bus.ReceiveLED);
    end
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    tick(4);
    n_cmp++;
    if (ws_cnt - w0 != 1 || bus.ReceiveLED !== 1'b1) begin
      n_err++;
      $display("FAIL word_strobe_led: ws=%0d led=%b, expected 1 1", ws_cnt - w0, bus.ReceiveLED);
    end
    n_cmp++;
    if (bus.WriteData !== 32'h12345678) begin
      n_err++;
      $display("FAIL word_hold: got %h, expected 12345678", bus.WriteData);
    end
    check_drained("b2b");
  endtask

  task automatic test_glitch();
    int b0, f0;
    do_reset();
    b0 = byte_cnt; f0 = ferr_cnt;
    bus.Rx = 1'b0;
    tick(3);
    bus.Rx = 1'b1;
    tick(30);
    n_cmp++;
    if (byte_cnt - b0 != 0 || ferr_cnt - f0 != 0) begin
      n_err++;
      $display("FAIL glitch_silent: bv=%0d fe=%0d, expected 0 0", byte_cnt - b0, ferr_cnt - f0);
    end
    send(8'h3C);
    tick(4);
    n_cmp++;
    if (byte_cnt - b0 != 1) begin
      n_err++;
      $display("FAIL glitch_recover: bv=%0d, expected 1", byte_cnt - b0);
    end
    check_drained("glitch");
  endtask

  task automatic test_frame_err();
    int b0, f0, w0;
    do_reset();
    b0 = byte_cnt; f0 = ferr_cnt; w0 = ws_cnt;
    send(8'h11);
    send_frame(8'h55, 1'b0, 40);
    tick(20);
    n_cmp++;
    if (ferr_cnt - f0 != 1 || byte_cnt - b0 != 1) begin
      n_err++;
      $display("FAIL frame_err: fe=%0d bv=%0d, expected 1 1", ferr_cnt - f0, byte_cnt - b0);
    end
    // Partial word 0x11 survives the error.
    send(8'h81); send(8'h22); send(8'h33);
    tick(4);
    n_cmp++;
    if (ws_cnt - w0 != 1 || bus.WriteData !== 32'h11812233) begin
      n_err++;
      $display("FAIL frame_err_word: ws=%0d data=%h, expected 1 11812233",
               ws_cnt - w0, bus.WriteData);
    end
    check_drained("ferr");
  endtask

  task automatic test_timeout();
    int w0;
    do_reset();
    w0 = ws_cnt;
    send(8'hDE); send(8'hAD);
    tick(TMO - 20);
    n_cmp++;
    if (bus.ComActive !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_early: ComActive=%b, expected 1", bus.ComActive);
    end
    tick(30);
    n_cmp++;
    if (bus.ComActive !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_drop: ComActive=%b, expected 0", bus.ComActive);
    end
    m_idx = 0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick(4);
    n_cmp++;
    if (ws_cnt - w0 != 1 || bus.WriteData !== 32'h01020304) begin
      n_err++;
      $display("FAIL timeout_realign: ws=%0d data=%h, expected 1 01020304",
               ws_cnt - w0, bus.WriteData);
    end
    check_drained("timeout");
  endtask

  task automatic test_rst_mid_frame();
    int b0, w0;
    logic [7:0] d;
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.Rx = d[4];
    tick(CPB / 2);
    rst    = 1'b1;
    bus.Rx = 1'b1;
    tick(1);
    rst = 1'b0;
    model_clear();
    b0 = byte_cnt; w0 = ws_cnt;
    tick(1);
    n_cmp++;
    if ({bus.ByteValid, bus.FrameErr, bus.WriteStrobe, bus.ComActive, bus.ReceiveLED} !== 5'b0 ||
        bus.WriteData !== 32'h0 || bus.ByteData !== 8'h0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: flags=%b data=%h byte=%h, expected 00000 00000000 00",
               {bus.ByteValid, bus.FrameErr, bus.WriteStrobe, bus.ComActive, bus.ReceiveLED},
               bus.WriteData, bus.ByteData);
    end
    tick(30);
    n_cmp++;
    if (byte_cnt - b0 != 0 || ws_cnt - w0 != 0) begin
      n_err++;
      $display("FAIL rst_mid_silent: bv=%0d ws=%0d, expected 0 0", byte_cnt - b0, ws_cnt - w0);
    end
    send(8'hF0);
    tick(4);
    n_cmp++;
    if (byte_cnt - b0 != 1) begin
      n_err++;
      $display("FAIL rst_mid_recover: bv=%0d, expected 1", byte_cnt - b0);
    end
    check_drained("rst_mid");
  endtask

  initial begin
    bus.Rx = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_timeout();
    test_rst_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
